// File: rtl/alu_accu_param_if.sv
// Request channel of the accumulator ALU: valid/ready handshake plus opcode and immediate operand.
interface alu_accu_param_if #(
    parameter int WIDTH = 7
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand;

    modport master (output op_valid, output opcode, output operand, input  op_ready);
    modport slave  (input  op_valid, input  opcode, input  operand, output op_ready);
endinterface

// File: rtl/alu_accu_param.sv
// Parametrised accumulator ALU: single-cycle LOAD/ADD/SUB/logic/shift ops with status flags.
// Optional shift-add multiplier (opcode 10) is compiled in only when ALU_MUL_EN is defined.
module alu_accu_param #(
    parameter int WIDTH = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_accu_param_if.slave    bus,
    output logic [WIDTH-1:0]   accu,
    output logic               carry,
    output logic               ovf,
    output logic               zero,
    output logic               neg,
    output logic               busy,
    output logic               done
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_CLC  = 4'd9,
        OP_MUL  = 4'd10
    } opcode_e;

    logic [WIDTH-1:0] r_accu;
    logic             r_carry;
    logic             r_ovf;
    logic             r_done;

    logic             w_accept;
    logic             w_op_ready;
    logic             w_busy;
    logic             w_mul_start;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_accu_nxt;
    logic             w_carry_nxt;
    logic             w_ovf_nxt;

    assign w_accept = bus.op_valid && w_op_ready;

    // Carry-in participates in ADD, so the WIDTH+1 bit sum yields carry-out directly.
    assign w_add = {1'b0, r_accu} + {1'b0, bus.operand} + {{WIDTH{1'b0}}, r_carry};
    assign w_sub = r_accu - bus.operand;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_accu_nxt  = r_accu;
        w_carry_nxt = r_carry;
        w_ovf_nxt   = r_ovf;
        case (bus.opcode)
            OP_LOAD: begin
                w_accu_nxt = bus.operand;
                w_ovf_nxt  = 1'b0;
            end
            OP_ADD: begin
                w_accu_nxt  = w_add[WIDTH-1:0];
                w_carry_nxt = w_add[WIDTH];
                w_ovf_nxt   = (r_accu[MSB] == bus.operand[MSB]) && (w_add[MSB] != r_accu[MSB]);
            end
            OP_SUB: begin
                w_accu_nxt  = w_sub;
                w_carry_nxt = (bus.operand > r_accu);
                w_ovf_nxt   = (r_accu[MSB] != bus.operand[MSB]) && (w_sub[MSB] != r_accu[MSB]);
            end
            OP_AND: begin
                w_accu_nxt = r_accu & bus.operand;
                w_ovf_nxt  = 1'b0;
            end
            OP_OR: begin
                w_accu_nxt = r_accu | bus.operand;
                w_ovf_nxt  = 1'b0;
            end
            OP_XOR: begin
                w_accu_nxt = r_accu ^ bus.operand;
                w_ovf_nxt  = 1'b0;
            end
            OP_SHL: begin
                w_accu_nxt  = {r_accu[WIDTH-2:0], 1'b0};
                w_carry_nxt = r_accu[MSB];
                w_ovf_nxt   = 1'b0;
            end
            OP_SHR: begin
                w_accu_nxt  = {1'b0, r_accu[WIDTH-1:1]};
                w_carry_nxt = r_accu[0];
                w_ovf_nxt   = 1'b0;
            end
            OP_CLC: begin
                w_carry_nxt = 1'b0;
                w_ovf_nxt   = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_psum;
    logic               w_mul_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_ready  = 1'b0;
        w_busy      = 1'b0;
        w_mul_start = 1'b0;
        w_mul_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_op_ready = 1'b1;
                if (bus.op_valid && bus.opcode == OP_MUL) begin
                    w_mul_start = 1'b1;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_mul_last  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The accumulator is frozen during MUL, so it serves as the multiplicand; the
    // multiplier rides in the low half of r_prod and is consumed LSB first.
    assign w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_accu} : '0);
    assign w_prod_nxt = {w_psum, r_prod[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (w_mul_start) begin
            r_prod <= {{WIDTH{1'b0}}, bus.operand};
            r_cnt  <= '0;
        end else if (w_busy) begin
            r_prod <= w_prod_nxt;
            r_cnt  <= r_cnt + CW'(1);
        end
    end
`else
    assign w_op_ready  = 1'b1;
    assign w_busy      = 1'b0;
    assign w_mul_start = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accu  <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_mul_start) begin
                r_accu  <= w_accu_nxt;
                r_carry <= w_carry_nxt;
                r_ovf   <= w_ovf_nxt;
                r_done  <= 1'b1;
            end
`ifdef ALU_MUL_EN
            else if (w_mul_last) begin
                r_accu  <= w_prod_nxt[WIDTH-1:0];
                r_carry <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                r_ovf   <= 1'b0;
                r_done  <= 1'b1;
            end
`endif
        end
    end

    assign bus.op_ready = w_op_ready;
    assign accu         = r_accu;
    assign carry        = r_carry;
    assign ovf          = r_ovf;
    assign zero         = (r_accu == '0);
    assign neg          = r_accu[MSB];
    assign busy         = w_busy;
    assign done         = r_done;
endmodule

// File: tb/tb_alu_accu_param.sv
// Directed self-checking bench for alu_accu_param at WIDTH=7; MUL steps follow ALU_MUL_EN.
module tb_alu_accu_param;
    localparam int WIDTH = 7;

    localparam logic [3:0] NOP = 4'd0, LOAD = 4'd1, ADD = 4'd2, SUB = 4'd3, AND_ = 4'd4,
                           OR_ = 4'd5, XOR_ = 4'd6, SHL = 4'd7, SHR = 4'd8, CLC = 4'd9,
                           MUL = 4'd10;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic [WIDTH-1:0] accu;
    logic             carry, ovf, zero, neg, busy, done;

    int checks   = 0;
    int failures = 0;

    alu_accu_param_if #(.WIDTH(WIDTH)) bus ();

    alu_accu_param #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .accu  (accu),
        .carry (carry),
        .ovf   (ovf),
        .zero  (zero),
        .neg   (neg),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request before an edge, drop it just after; outputs sampled #1 after the edge.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] opd);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = op;
        bus.operand  = opd;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk_en       = 1'b1;
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.opcode   = NOP;
        bus.operand  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_accu", 16'(accu), 16'h00);
        check("rst_carry", 16'(carry), 16'h0);
        check("rst_zero", 16'(zero), 16'h1);
        check("rst_ready", 16'(bus.op_ready), 16'h1);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);

        // Release from reset together with a request: that first edge accepts it.
        @(negedge clk);
        rst_n        = 1'b1;
        bus.op_valid = 1'b1;
        bus.opcode   = LOAD;
        bus.operand  = 7'h11;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check("rel_load_accu", 16'(accu), 16'h11);
        check("rel_load_done", 16'(done), 16'h1);
        idle_cycle();
        check("done_one_cycle", 16'(done), 16'h0);

        // ADD wrap with carry-in on the following ADD.
        issue(LOAD, 7'h7F);
        check("load7f_accu", 16'(accu), 16'h7F);
        check("load7f_neg", 16'(neg), 16'h1);
        issue(ADD, 7'h01);
        check("addwrap_accu", 16'(accu), 16'h00);
        check("addwrap_carry", 16'(carry), 16'h1);
        check("addwrap_zero", 16'(zero), 16'h1);
        check("addwrap_ovf", 16'(ovf), 16'h0);
        check("addwrap_done", 16'(done), 16'h1);
        issue(ADD, 7'h00);
        check("addcin_accu", 16'(accu), 16'h01);
        check("addcin_carry", 16'(carry), 16'h0);
        check("addcin_done", 16'(done), 16'h1);

        // Signed overflow on ADD and SUB, then borrow.
        issue(CLC, 7'h00);
        check("clc_carry", 16'(carry), 16'h0);
        issue(LOAD, 7'h3F);
        issue(ADD, 7'h01);
        check("addovf_accu", 16'(accu), 16'h40);
        check("addovf_ovf", 16'(ovf), 16'h1);
        check("addovf_neg", 16'(neg), 16'h1);
        issue(LOAD, 7'h40);
        check("load_clr_ovf", 16'(ovf), 16'h0);
        issue(SUB, 7'h01);
        check("subovf_accu", 16'(accu), 16'h3F);
        check("subovf_ovf", 16'(ovf), 16'h1);
        check("subovf_carry", 16'(carry), 16'h0);
        issue(LOAD, 7'h05);
        issue(SUB, 7'h07);
        check("subbor_accu", 16'(accu), 16'h7E);
        check("subbor_carry", 16'(carry), 16'h1);
        check("subbor_neg", 16'(neg), 16'h1);
        check("subbor_ovf", 16'(ovf), 16'h0);

        // Logic and shifts; carry=1 must survive LOAD and XOR.
        issue(LOAD, 7'h55);
        check("load_keep_carry", 16'(carry), 16'h1);
        issue(XOR_, 7'h7F);
        check("xor_accu", 16'(accu), 16'h2A);
        check("xor_keep_carry", 16'(carry), 16'h1);
        issue(SHL, 7'h00);
        check("shl_accu", 16'(accu), 16'h54);
        check("shl_carry", 16'(carry), 16'h0);
        issue(SHR, 7'h00);
        check("shr_accu", 16'(accu), 16'h2A);
        check("shr_carry", 16'(carry), 16'h0);
        issue(AND_, 7'h0F);
        check("and_accu", 16'(accu), 16'h0A);
        issue(OR_, 7'h41);
        check("or_accu", 16'(accu), 16'h4B);
        issue(SHL, 7'h00);
        check("shl2_accu", 16'(accu), 16'h16);
        check("shl2_carry", 16'(carry), 16'h1);
        issue(SHR, 7'h00);
        issue(SHR, 7'h00);
        check("shr2_accu", 16'(accu), 16'h05);
        check("shr2_carry", 16'(carry), 16'h1);

        // NOPs pulse done and leave state alone.
        issue(NOP, 7'h7F);
        check("nop_accu", 16'(accu), 16'h05);
        check("nop_carry", 16'(carry), 16'h1);
        check("nop_done", 16'(done), 16'h1);
        issue(4'd15, 7'h33);
        check("op15_accu", 16'(accu), 16'h05);
        check("op15_done", 16'(done), 16'h1);
        issue(CLC, 7'h00);
        check("clc2_carry", 16'(carry), 16'h0);
        check("clc2_accu", 16'(accu), 16'h05);

`ifdef ALU_MUL_EN
        // 12 * 11 = 132 = 0x84 -> low 7 bits 0x04, high part nonzero.
        issue(LOAD, 7'd12);
        issue(MUL, 7'd11);
        check("mul_busy0", 16'(busy), 16'h1);
        check("mul_ready0", 16'(bus.op_ready), 16'h0);
        check("mul_done0", 16'(done), 16'h0);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = ADD;
        bus.operand  = 7'h01;
        for (int k = 1; k < WIDTH; k++) begin
            idle_cycle();
            check("mul_busy_k", 16'(busy), 16'h1);
            check("mul_done_k", 16'(done), 16'h0);
            check("mul_hold_accu", 16'(accu), 16'd12);
        end
        idle_cycle();
        check("mul_res_accu", 16'(accu), 16'h04);
        check("mul_res_carry", 16'(carry), 16'h1);
        check("mul_res_ovf", 16'(ovf), 16'h0);
        check("mul_res_done", 16'(done), 16'h1);
        check("mul_res_busy", 16'(busy), 16'h0);
        check("mul_res_ready", 16'(bus.op_ready), 16'h1);
        // The held ADD is accepted on the next edge: 4 + 1 + carry 1.
        idle_cycle();
        bus.op_valid = 1'b0;
        check("post_mul_add", 16'(accu), 16'h06);
        check("post_mul_carry", 16'(carry), 16'h0);

        // Reset three cycles into a MUL discards it.
        issue(LOAD, 7'd3);
        issue(MUL, 7'd5);
        repeat (2) idle_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mulrst_busy", 16'(busy), 16'h0);
        check("mulrst_accu", 16'(accu), 16'h00);
        check("mulrst_ready", 16'(bus.op_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen_done = 0;
            for (int k = 0; k < 2 * WIDTH; k++) begin
                idle_cycle();
                if (done) seen_done++;
            end
            check("mulrst_no_done", 16'(seen_done), 16'd0);
        end
        check("mulrst_accu_end", 16'(accu), 16'h00);
`else
        issue(LOAD, 7'h2C);
        issue(MUL, 7'd11);
        check("mul_nop_accu", 16'(accu), 16'h2C);
        check("mul_nop_busy", 16'(busy), 16'h0);
        check("mul_nop_ready", 16'(bus.op_ready), 16'h1);
        check("mul_nop_done", 16'(done), 16'h1);
        idle_cycle();
        check("mul_nop_busy2", 16'(busy), 16'h0);
`endif

        // Asynchronous reset with the clock stopped, right after an op sets ovf and done.
        issue(LOAD, 7'h3F);
        issue(ADD, 7'h01);
        check("pre_arst_ovf", 16'(ovf), 16'h1);
        clk_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_accu", 16'(accu), 16'h00);
        check("arst_carry", 16'(carry), 16'h0);
        check("arst_ovf", 16'(ovf), 16'h0);
        check("arst_zero", 16'(zero), 16'h1);
        check("arst_neg", 16'(neg), 16'h0);
        check("arst_ready", 16'(bus.op_ready), 16'h1);
        check("arst_done", 16'(done), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_accu_param.md
# alu_accu_param

Parametrised accumulator ALU, the next generation of the team's 7-bit accumulator block. It holds a WIDTH-bit accumulator and a set of status flags. It executes one opcode per accepted request from a valid/ready interface, with immediate operands. It adds logic, shift and a multi-cycle shift-add multiply to the LOAD/ADD/SUB set. The top level drives it from the input switches and bidirectional pins and shows `accu`/`carry` on the display outputs.

## Interface
- `WIDTH`, default 7: accumulator and operand width; legal range 4 to 16.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `op_valid`  input  1  request present.
- `op_ready`  output  1  block can accept a request.
- `opcode`  input  4  operation select.
- `operand`  input  WIDTH  immediate operand.
- `accu`  output  WIDTH  accumulator contents (registered).
- `carry`  output  1  carry/borrow flag (registered).
- `ovf`  output  1  signed overflow flag (registered).
- `zero`  output  1  `accu == 0` (combinational from `accu`).
- `neg`  output  1  `accu[WIDTH-1]`.
- `busy`  output  1  multiply in progress.
- `done`  output  1  one-cycle pulse: result of an accepted op is visible.

## Operation
- **Accept rule:** an op is accepted on a rising edge where `op_valid && op_ready`. `opcode` and `operand` are sampled only at that edge.
- **Opcodes:**
  - 0 NOP.
  - 1 LOAD: `accu<=operand`. Carry unchanged; `ovf<=0`.
  - 2 ADD: `{carry,accu}<=accu+operand+carry`. `ovf` = signed overflow.
  - 3 SUB: `accu<=accu-operand`. `carry<=1` iff `operand>accu` as unsigned (borrow). `ovf` = signed overflow.
  - 4 AND, 5 OR, 6 XOR: bitwise with `operand`. Carry unchanged; `ovf<=0`.
  - 7 SHL: `accu<=accu<<1`, `carry<=` old MSB. `ovf<=0`.
  - 8 SHR (logical): `carry<=` old LSB. `ovf<=0`.
  - 9 CLC: `carry<=0`, `ovf<=0`. Accumulator unchanged.
  - 10 MUL: see Configuration.
  - 11–15: NOP.
- **States:**
  - IDLE: `op_ready=1`, `busy=0`.
  - MUL: `op_ready=0`, `busy=1`. Only an accepted MUL leaves IDLE.
- **MUL:** unsigned `accu*operand`, computed shift-add over exactly WIDTH iterations.
  - On completion: `accu<=` low WIDTH bits of the product.
  - `carry<=1` iff the high WIDTH bits are nonzero.
  - `ovf<=0`.
  - While in MUL, `accu` and the flags keep their pre-MUL values.
- **`op_valid` during MUL:** ignored and not queued. The requester must hold the request until it sees `op_ready`.
- **Reset (asynchronous, any time, including mid-MUL):**
  - `accu=0`, `carry=0`, `ovf=0`, `busy=0`, `done=0`, state IDLE, `op_ready=1`.
  - Hence `zero=1`, `neg=0`.
  - A MUL in progress is discarded.

## Timing
- **Single-cycle ops (0–9, 11–15):**
  - Accepted at edge N; result and flags visible after edge N.
  - `done=1` for the cycle after edge N only.
  - Back-to-back acceptance every cycle.
- **MUL:**
  - Accepted at edge N; `busy`/`!op_ready` from after edge N.
  - Result loaded at edge N+WIDTH, so latency is WIDTH cycles.
  - `done=1` and `busy=0` in the cycle after edge N+WIDTH.
  - `op_ready=1` again in that same cycle, so a new op may be accepted at edge N+WIDTH+1.
- **NOP:** still pulses `done` when accepted.
- **Release from reset:** takes effect on the first edge with `rst_n` high. An `op_valid` on that edge is accepted.

## Configuration
- **`ALU_MUL_EN` defined:**
  - Multiply iteration counter (`$clog2(WIDTH+1)` bits) compiled in.
  - Partial-product register (2·WIDTH bits) compiled in.
  - MUL state compiled in.
  - Opcode 10 behaves as above.
- **`ALU_MUL_EN` undefined:**
  - Opcode 10 is a single-cycle NOP.
  - `busy` is tied 0 and `op_ready` is tied 1.
  - No multiplier logic is present.

## Test plan
- **Reset:** assert `rst_n=0` mid-cycle with `clk` stopped → `accu=0`, `carry=0`, `ovf=0`, `zero=1`, `op_ready=1` immediately.
- **ADD wrap (WIDTH=7):** LOAD 0x7F, ADD 0x01 → `accu=0x00`, `carry=1`, `zero=1`, `done` pulses each op. Then ADD 0x00 → `accu=0x01`, `carry=0`.
- **Signed overflow (WIDTH=7):** CLC, LOAD 0x3F, ADD 0x01 → `accu=0x40`, `ovf=1`, `neg=1`. Then SUB 0x07 from LOAD 0x05 → `accu=0x7E`, `carry=1`, `neg=1`.
- **MUL with `ALU_MUL_EN` (WIDTH=7):**
  - LOAD 12, MUL 11 → `busy` for 7 cycles, `op_ready=0`.
  - An `op_valid` with ADD during busy is ignored.
  - Result: `accu=0x04`, `carry=1`, single `done` pulse 7 cycles after acceptance.
- **Reset mid-MUL:** pulse `rst_n` low 3 cycles into a MUL → `busy=0`, `accu=0`. No `done` pulse follows.
- **Logic/shift, and MUL without macro:**
  - LOAD 0x55, XOR 0x7F → `0x2A`; SHL → `0x54`, `carry=0`; SHR → `0x2A`, `carry=0`.
  - Build without `ALU_MUL_EN`: opcode 10 leaves `accu` unchanged and `busy` stays 0.
